pc_gen: RTL

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen_pkg.sv | 15 +
 rtl/pc_gen_ras_stack.sv | 62 ++++++
 rtl/pc_gen.sv | 98 +++++++++
 3 files changed

// File: rtl/pc_gen_pkg.sv
// rtl/pc_gen_pkg.sv - next-PC select encoding and default vectors for pc_gen
package pc_gen_pkg;

  typedef enum logic [2:0] {
    SEL_EXC   = 3'd0,
    SEL_REDIR = 3'd1,
    SEL_RET   = 3'd2,
    SEL_HOLD  = 3'd3,
    SEL_SEQ   = 3'd4
  } next_sel_e;

  localparam int unsigned DEF_RESET_VEC = 32'h0000_0000;
  localparam int unsigned DEF_EXC_VEC   = 32'h0000_0040;

endpackage

// File: rtl/pc_gen_ras_stack.sv
// rtl/pc_gen_ras_stack.sv - circular return-address stack; a push when full overwrites the oldest entry
module ras_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW:0]      r_count;
  logic             r_overflow;
  logic             r_underflow;
  logic [PW-1:0]    w_top_idx;

  assign w_top_idx = r_wr_ptr - PW'(1);
  assign top       = r_mem[w_top_idx];
  assign empty     = (r_count == '0);
  assign full      = (r_count == (PW+1)'(DEPTH));
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

  // Entry contents carry no reset; only pointer and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= push && full;
      r_underflow <= pop && !push && empty;
      if (push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
        if (!full) begin
          r_count <= r_count + (PW+1)'(1);
        end
      end else if (pop && !empty) begin
        r_wr_ptr <= r_wr_ptr - PW'(1);
        r_count  <= r_count - (PW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch PC generator with exception, redirect, call/return stack and stall
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int          WIDTH     = 16,
  parameter int          INC       = 2,
  parameter int unsigned RESET_VEC = DEF_RESET_VEC,
  parameter int unsigned EXC_VEC   = DEF_EXC_VEC,
  parameter int          RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             call,
  input  logic             ret,
  input  logic             exc,
  output logic [WIDTH-1:0] pc,
  output logic             pc_valid,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_err
);

  logic [WIDTH-1:0] r_pc;
  logic             r_pc_valid;
  next_sel_e        w_sel;
  logic [WIDTH-1:0] w_pc_inc;
  logic [WIDTH-1:0] w_pc_next;
  logic [WIDTH-1:0] w_ras_top;
  logic             w_push;
  logic             w_pop;
  logic             w_ras_empty;
  logic             w_ras_full;
  logic             w_overflow;
  logic             w_underflow;

  always_comb begin
    w_sel = SEL_SEQ;
    if (exc)                 w_sel = SEL_EXC;
    else if (redirect_valid) w_sel = SEL_REDIR;
    else if (ret)            w_sel = SEL_RET;
    else if (stall)          w_sel = SEL_HOLD;
  end

  assign w_pc_inc = r_pc + WIDTH'(INC);

  // The first edge after reset only marks RESET_VEC live, so the stack is untouched then.
  assign w_push = r_pc_valid && (w_sel == SEL_REDIR) && call;
  assign w_pop  = r_pc_valid && (w_sel == SEL_RET);

  always_comb begin
    w_pc_next = r_pc;
    case (w_sel)
      SEL_EXC:   w_pc_next = WIDTH'(EXC_VEC);
      SEL_REDIR: w_pc_next = redirect_target;
      SEL_RET:   w_pc_next = w_ras_empty ? w_pc_inc : w_ras_top;
      SEL_HOLD:  w_pc_next = r_pc;
      SEL_SEQ:   w_pc_next = w_pc_inc;
      default:   w_pc_next = r_pc;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc       <= WIDTH'(RESET_VEC);
      r_pc_valid <= 1'b0;
    end else if (!r_pc_valid) begin
      r_pc_valid <= 1'b1;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  ras_stack #(
    .DEPTH(RAS_DEPTH),
    .WIDTH(WIDTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (w_pc_inc),
    .top       (w_ras_top),
    .empty     (w_ras_empty),
    .full      (w_ras_full),
    .overflow  (w_overflow),
    .underflow (w_underflow)
  );

  assign pc        = r_pc;
  assign pc_valid  = r_pc_valid;
  assign ras_empty = w_ras_empty;
  assign ras_full  = w_ras_full;
  assign ras_err   = w_overflow | w_underflow;

endmodule
